// File: rtl/cdc_uart_pkg.sv
// Shared constants for the CDC byte-stream <-> UART bridge: FSM encodings,
// synchronizer depth and a width helper.
package cdc_uart_pkg;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam int SYNC_STAGES = 2;

  // Smallest r with (1 << r) >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fallthrough FIFO with registered full/empty flags; a push into a
// registered-full FIFO is refused even if a pop happens in the same cycle.
module sync_fifo
  import cdc_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    do_push = push_i & ~full_q;
    do_pop  = pop_i & ~empty_q;
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    empty_d = (wr_d == rd_d);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign data_o  = empty_q ? '0 : mem_q[rd_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/cdc_uart_bridge.sv
// CDC bulk OUT bytes -> UART TX (8N1, LSB first), UART RX -> CDC bulk IN bytes,
// each direction buffered by a FWFT FIFO, all in the clk_i domain.
module cdc_uart_bridge
  import cdc_uart_pkg::*;
#(
  parameter int BIT_CYCLES = 417,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       uart_tx_o,
  input  logic       uart_rx_i,
  output logic       frame_err_o,
  output logic       rx_overrun_o
);

  localparam int             CW       = clog2(BIT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MID  = CW'(BIT_CYCLES / 2 - 1);

  logic       rdy_en_q;
  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rdy_en_q <= 1'b0;
    else         rdy_en_q <= 1'b1;
  end

  assign out_ready_o = rdy_en_q & ~tx_full;
  assign in_valid_o  = ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i, .rstn_i,
    .push_i (out_valid_i & rdy_en_q),
    .data_i (out_data_i),
    .pop_i  (tx_pop),
    .data_o (tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  // ---------------- TX ----------------
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_last;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    tx_last    = (tx_cnt_q == CNT_LAST);
    tx_cnt_d   = (tx_state_q == TX_IDLE || tx_last) ? '0 : tx_cnt_q + CW'(1);
    case (tx_state_q)
      TX_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_head;
        tx_state_d = TX_START;
        tx_line_d  = 1'b0;
      end
      TX_START: if (tx_last) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = 3'd0;
        tx_line_d  = tx_shift_q[0];
      end
      TX_DATA: if (tx_last) begin
        if (tx_idx_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
        end else begin
          tx_idx_d   = tx_idx_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_line_d  = tx_shift_q[1];
        end
      end
      TX_STOP: if (tx_last) begin
        // Back-to-back frames: reload straight into START with no idle bit.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_state_d = TX_START;
          tx_line_d  = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
          tx_line_d  = 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx_o = tx_line_q;

  // ---------------- RX ----------------
  logic [SYNC_STAGES:0] rx_sync_q, rx_sync_d;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic                 ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 rx_bit, rx_fall, rx_last;

  assign rx_sync_d = {rx_sync_q[SYNC_STAGES-1:0], uart_rx_i};
  assign rx_bit    = rx_sync_q[SYNC_STAGES-1];
  assign rx_fall   = rx_sync_q[SYNC_STAGES] & ~rx_sync_q[SYNC_STAGES-1];
  assign rx_last   = (rx_cnt_q == CNT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == CNT_MID) begin
        rx_cnt_d   = '0;
        rx_idx_d   = 3'd0;
        rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_last) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_bit, rx_shift_q[7:1]};
        if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_idx_d   = rx_idx_q + 3'd1;
      end
      RX_STOP: if (rx_last) begin
        rx_cnt_d = '0;
        if (rx_bit) begin
          rx_state_d = RX_IDLE;
          if (rx_full) ovr_d   = 1'b1;
          else         rx_push = 1'b1;
        end else begin
          ferr_d     = 1'b1;
          rx_state_d = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_bit) rx_state_d = RX_IDLE;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_sync_q  <= '1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i, .rstn_i,
    .push_i (rx_push),
    .data_i (rx_shift_q),
    .pop_i  (in_ready_i),
    .data_o (in_data_o),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  assign frame_err_o  = ferr_q;
  assign rx_overrun_o = ovr_q;

endmodule

// File: tb/tb_cdc_uart_bridge.sv
// Directed bench for cdc_uart_bridge with BIT_CYCLES=8, FIFO_DEPTH=4.
module tb_cdc_uart_bridge;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] out_data_i = '0;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b1;
  logic       uart_tx_o;
  logic       uart_rx_i = 1'b1;
  logic       frame_err_o;
  logic       rx_overrun_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_hi = 0;
  int last_low_cyc = -1;
  logic [7:0] rxq[$];

  cdc_uart_bridge #(.BIT_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i),
    .frame_err_o(frame_err_o), .rx_overrun_o(rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (frame_err_o)  ferr_cnt <= ferr_cnt + 1;
    if (rx_overrun_o) ovr_cnt  <= ovr_cnt + 1;
    if (frame_err_o && rx_overrun_o) both_hi <= both_hi + 1;
    if (!uart_tx_o) last_low_cyc <= cyc;
    if (in_valid_o && in_ready_i) rxq.push_back(in_data_o);
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level per clock for one frame, sample 0 being the first START clock.
  function automatic logic [79:0] exp_wave(input logic [7:0] b);
    logic [79:0] w;
    for (int k = 0; k < 80; k++)
      w[k] = (k < 8) ? 1'b0 : (k < 72) ? b[(k - 8) / 8] : 1'b1;
    return w;
  endfunction

  task automatic push_byte(input logic [7:0] b, output int stalls);
    logic ok;
    stalls = 0;
    out_data_i = b;
    out_valid_i = 1'b1;
    do begin
      ok = out_ready_o;
      @(posedge clk_i); #1;
      if (!ok) stalls++;
    end while (!ok && stalls < 500);
    out_valid_i = 1'b0;
  endtask

  task automatic tx_frame(output logic [79:0] w, output int t0);
    int n;
    n = 0;
    w = '1;
    t0 = -1;
    while (uart_tx_o !== 1'b0 && n < 2000) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("tx_start_seen", 80'(uart_tx_o), 80'(0));
    if (uart_tx_o === 1'b0) begin
      t0 = cyc;
      w[0] = uart_tx_o;
      for (int k = 1; k < 80; k++) begin
        @(posedge clk_i); #1;
        w[k] = uart_tx_o;
      end
    end
  endtask

  // Bits alternate la (even index: start, d1, d3, ...) and lb (odd index).
  task automatic rx_send(input logic [7:0] b, input int la, input int lb,
                         input logic stop_v, input int stop_len);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_rx_i = fr[j];
      repeat (j == 9 ? stop_len : ((j % 2 == 0) ? la : lb)) @(posedge clk_i);
      #1;
    end
    uart_rx_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [79:0] w;
    logic [79:0] ws[6];
    int t0s[6];
    int t0, st, st_sum, st6, base, f0, o0, rel_cyc;
    logic [7:0] tx_bytes[6];
    logic [7:0] rx_bytes[5];
    tx_bytes = '{8'h5A, 8'h01, 8'hFF, 8'h80, 8'hC3, 8'h7E};
    rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_out_ready", 80'(out_ready_o), 80'(0));
    chk("rst_in_valid", 80'(in_valid_o), 80'(0));
    chk("rst_in_data", 80'(in_data_o), 80'(0));
    chk("rst_uart_tx", 80'(uart_tx_o), 80'(1));
    chk("rst_errs", 80'({frame_err_o, rx_overrun_o}), 80'(0));
    rstn_i = 1'b1;
    #1;
    chk("rel_ready_before_clk", 80'(out_ready_o), 80'(0));
    @(posedge clk_i); #1;
    chk("rel_ready_after_clk", 80'(out_ready_o), 80'(1));

    // 1: single byte A5
    push_byte(8'hA5, st);
    chk("t1_stalls", 80'(st), 80'(0));
    tx_frame(w, t0);
    chk("t1_wave_A5", w, exp_wave(8'hA5));
    chk("t1_ready", 80'(out_ready_o), 80'(1));
    repeat (5) @(posedge clk_i);
    #1;

    // 2: burst of 6 while TX busy; 5 accepted back-to-back, the 6th waits
    st_sum = 0;
    st6 = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push_byte(tx_bytes[i], st);
          st_sum += st;
        end
        chk("t2_ready_full", 80'(out_ready_o), 80'(0));
        push_byte(tx_bytes[5], st6);
      end
      begin
        for (int i = 0; i < 6; i++) tx_frame(ws[i], t0s[i]);
      end
    join
    chk("t2_first5_no_stall", 80'(st_sum), 80'(0));
    chk("t2_sixth_stalled", 80'(st6 > 60 && st6 < 100), 80'(1));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_wave_%0d", i), ws[i], exp_wave(tx_bytes[i]));
      if (i > 0) chk($sformatf("t2_gap_%0d", i), 80'(t0s[i] - t0s[i-1]), 80'(80));
    end
    chk("t2_ready_back", 80'(out_ready_o), 80'(1));

    // 3: RX 3C at 8 clocks/bit and with 7/9 clock bit jitter
    f0 = ferr_cnt;
    base = rxq.size();
    rx_send(8'h3C, 8, 8, 1'b1, 8);
    rx_send(8'h3C, 7, 9, 1'b1, 9);
    rx_send(8'h3C, 9, 7, 1'b1, 7);
    repeat (4) @(posedge clk_i);
    #1;
    chk("t3_count", 80'(rxq.size() - base), 80'(3));
    for (int i = 0; i < 3; i++)
      if (rxq.size() > base + i) chk($sformatf("t3_byte_%0d", i), 80'(rxq[base+i]), 80'(8'h3C));
    chk("t3_no_ferr", 80'(ferr_cnt - f0), 80'(0));

    // 4: 2-clock low glitch
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    base = rxq.size();
    uart_rx_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    uart_rx_i = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;
    chk("t4_no_push", 80'(rxq.size() - base), 80'(0));
    chk("t4_no_errs", 80'((ferr_cnt - f0) + (ovr_cnt - o0)), 80'(0));

    // 5: stop bit low for 30 clocks, then a good 55
    f0 = ferr_cnt;
    base = rxq.size();
    rx_send(8'hA3, 8, 8, 1'b0, 30);
    chk("t5_ferr_once", 80'(ferr_cnt - f0), 80'(1));
    chk("t5_no_push", 80'(rxq.size() - base), 80'(0));
    rx_send(8'h55, 8, 8, 1'b1, 8);
    repeat (4) @(posedge clk_i);
    #1;
    chk("t5_next_count", 80'(rxq.size() - base), 80'(1));
    if (rxq.size() > base) chk("t5_next_byte", 80'(rxq[base]), 80'(8'h55));

    // 6: overrun with in_ready_i held low
    in_ready_i = 1'b0;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    base = rxq.size();
    for (int i = 0; i < 5; i++) rx_send(rx_bytes[i], 8, 8, 1'b1, 8);
    chk("t6_ovr_once", 80'(ovr_cnt - o0), 80'(1));
    chk("t6_no_ferr", 80'(ferr_cnt - f0), 80'(0));
    chk("t6_valid_held", 80'(in_valid_o), 80'(1));
    chk("t6_head", 80'(in_data_o), 80'(8'h11));
    in_ready_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    chk("t6_drain_count", 80'(rxq.size() - base), 80'(4));
    for (int i = 0; i < 4; i++)
      if (rxq.size() > base + i) chk($sformatf("t6_drain_%0d", i), 80'(rxq[base+i]), 80'(rx_bytes[i]));
    chk("t6_empty", 80'(in_valid_o), 80'(0));

    // 7: reset during a TX data bit with an RX byte pending
    in_ready_i = 1'b0;
    rx_send(8'h77, 8, 8, 1'b1, 8);
    chk("t7_rx_pending", 80'(in_valid_o), 80'(1));
    push_byte(8'h00, st);
    st = 0;
    while (uart_tx_o !== 1'b0 && st < 50) begin
      @(posedge clk_i); #1;
      st++;
    end
    repeat (30) @(posedge clk_i);
    #1;
    chk("t7_mid_data_low", 80'(uart_tx_o), 80'(0));
    #3 rstn_i = 1'b0;
    #1;
    chk("t7_tx_async_high", 80'(uart_tx_o), 80'(1));
    chk("t7_in_valid", 80'(in_valid_o), 80'(0));
    chk("t7_out_ready", 80'(out_ready_o), 80'(0));
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    rel_cyc = cyc;
    repeat (200) @(posedge clk_i);
    #1;
    chk("t7_tx_silent", 80'(last_low_cyc < rel_cyc), 80'(1));
    chk("t7_in_valid_after", 80'(in_valid_o), 80'(0));
    chk("t7_ready_after", 80'(out_ready_o), 80'(1));

    chk("err_pulses_exclusive", 80'(both_hi), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
